// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the IF and DM ports.
// Define ARB_RR_EN for round-robin tie-breaking instead of fixed DM-over-IF priority.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  typedef enum logic {IDLE, BUSY} state_e;
  typedef enum logic {OWN_IF, OWN_DM} owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_ready_q, if_ready_d;
  logic              dm_ready_q, dm_ready_d;
  logic              if_elig, dm_elig;
  logic              grant_dm, done;
`ifdef ARB_RR_EN
  owner_e            last_q, last_d;
`endif

  // a port is blind in its own ready cycle so a held req is not reissued
  assign if_elig = if_req && !if_ready_q;
  assign dm_elig = dm_req && !dm_ready_q;

`ifdef ARB_RR_EN
  assign grant_dm = dm_elig && (!if_elig || last_q == OWN_IF);
`else
  assign grant_dm = dm_elig;
`endif

  assign done = (state_q == BUSY) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if_ready_d = 1'b0;
    dm_ready_d = 1'b0;
`ifdef ARB_RR_EN
    last_d     = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (if_elig || dm_elig) begin
          state_d = BUSY;
          cnt_d   = '0;
          owner_d = grant_dm ? OWN_DM : OWN_IF;
          addr_d  = grant_dm ? dm_addr : if_addr;
          we_d    = grant_dm && dm_we;
          wdata_d = grant_dm ? dm_wdata : '0;
`ifdef ARB_RR_EN
          last_d  = grant_dm ? OWN_DM : OWN_IF;
`endif
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (done) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (owner_q == OWN_DM) begin
            dm_ready_d = 1'b1;
            if (!we_q) dm_rdata_d = mem_rdata;
          end else begin
            if_ready_d = 1'b1;
            if_rdata_d = mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      cnt_q      <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_ready_q <= 1'b0;
      dm_ready_q <= 1'b0;
`ifdef ARB_RR_EN
      last_q     <= OWN_IF;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      if_ready_q <= if_ready_d;
      dm_ready_q <= dm_ready_d;
`ifdef ARB_RR_EN
      last_q     <= last_d;
`endif
    end
  end

  assign busy      = (state_q == BUSY);
  assign mem_en    = busy;
  assign mem_we    = busy && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ready  = if_ready_q;
  assign dm_ready  = dm_ready_q;

endmodule
